// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter
// Shares one account balance between N_REQ ATM terminals. Terminals request
// access and get a round-robin, exclusive grant. The granted terminal then
// issues one deposit or withdrawal, and the block reports the outcome.
// A grant held too long without an operation is reclaimed with TIMEOUT_ERR.
module atm_account_arbiter #(
  parameter int N_REQ   = 4,
  parameter int BAL_W   = 64,
  parameter int MONTO_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           REQ,
  input  logic [N_REQ-1:0]           OP_STB,
  input  logic [N_REQ-1:0]           OP_TIPO,
  input  logic [N_REQ*MONTO_W-1:0]   OP_MONTO,
  input  logic                       LOAD_STB,
  input  logic [BAL_W-1:0]           LOAD_VAL,
  output logic [N_REQ-1:0]           GNT,
  output logic [BAL_W-1:0]           BALANCE,
  output logic                       DONE,
  output logic                       OK,
  output logic                       FONDOS_INSUFICIENTES,
  output logic                       TIMEOUT_ERR
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  // Balance plus zero-extended amount, clamped to all-ones on overflow.
  function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                                input logic [MONTO_W-1:0] b);
    logic [BAL_W:0] s;
    s = {1'b0, a} + {{(BAL_W + 1 - MONTO_W){1'b0}}, b};
    sat_add = s[BAL_W] ? {BAL_W{1'b1}} : s[BAL_W-1:0];
  endfunction

  // Round-robin search starting just after the last winner. The MSB of the
  // result flags a hit. The loop runs from the farthest candidate to the
  // nearest, so the nearest requester is written last and wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDX_W-1:0] ptr);
    int j;
    rr_pick = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (req[j]) rr_pick = {1'b1, IDX_W'(j)};
    end
  endfunction

  logic [1:0]         r_state;
  logic [N_REQ-1:0]   r_gnt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ptr;
  logic [TMR_W-1:0]   r_timer;
  logic [BAL_W-1:0]   r_balance;
  logic               r_done;
  logic               r_ok;
  logic               r_nsf;
  logic               r_to;

  logic [IDX_W:0]     w_pick;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_stb;
  logic               w_tipo;
  logic               w_req_g;
  logic [MONTO_W-1:0] w_amt;
  logic [BAL_W-1:0]   w_amt_ext;
  logic               w_sufficient;
  logic               w_op_fire;

  // Select the winner and the signals of the granted terminal.
  always_comb begin
    w_pick       = rr_pick(REQ, r_ptr);
    w_pick_vld   = w_pick[IDX_W];
    w_pick_idx   = w_pick[IDX_W-1:0];
    w_stb        = OP_STB[r_idx];
    w_tipo       = OP_TIPO[r_idx];
    w_req_g      = REQ[r_idx];
    w_amt        = OP_MONTO[r_idx*MONTO_W +: MONTO_W];
    w_amt_ext    = BAL_W'(w_amt);
    w_sufficient = (r_balance >= w_amt_ext);
    w_op_fire    = (r_state == S_GRANT) && w_stb;
  end

  // Control FSM: arbitration, grant ownership and the grant timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= IDX_W'(N_REQ - 1);
      r_timer <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_gnt <= '0;
          // A load consumes this IDLE cycle; arbitration waits one cycle.
          if (!LOAD_STB && w_pick_vld) begin
            r_idx   <= w_pick_idx;
            r_ptr   <= w_pick_idx;
            r_gnt   <= N_REQ'(1) << w_pick_idx;
            r_timer <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_stb) begin
            r_state <= S_RESP;
          end else if (!w_req_g) begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_timer == TMR_LAST) begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_RESP: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Balance register: a load happens in IDLE, an operation when the strobe lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_balance <= '0;
    end else if (r_state == S_IDLE) begin
      if (LOAD_STB) r_balance <= LOAD_VAL;
    end else if (w_op_fire) begin
      if (!w_tipo)           r_balance <= sat_add(r_balance, w_amt);
      else if (w_sufficient) r_balance <= r_balance - w_amt_ext;
    end
  end

  // One-cycle result and timeout pulses; they clear on every cycle without an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
      r_ok   <= 1'b0;
      r_nsf  <= 1'b0;
      r_to   <= 1'b0;
    end else begin
      r_done <= w_op_fire;
      r_ok   <= w_op_fire && (!w_tipo || w_sufficient);
      r_nsf  <= w_op_fire && w_tipo && !w_sufficient;
      r_to   <= (r_state == S_GRANT) && !w_stb && w_req_g && (r_timer == TMR_LAST);
    end
  end

  assign GNT                  = r_gnt;
  assign BALANCE              = r_balance;
  assign DONE                 = r_done;
  assign OK                   = r_ok;
  assign FONDOS_INSUFICIENTES = r_nsf;
  assign TIMEOUT_ERR          = r_to;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Testbench for atm_account_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level reference.
module tb_atm_account_arbiter;

  localparam int N    = 4;
  localparam int BW   = 64;
  localparam int MW   = 32;
  localparam int TOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      REQ, OP_STB, OP_TIPO;
  logic [N*MW-1:0]   OP_MONTO;
  logic              LOAD_STB;
  logic [BW-1:0]     LOAD_VAL;
  logic [N-1:0]      GNT;
  logic [BW-1:0]     BALANCE;
  logic              DONE, OK, FONDOS_INSUFICIENTES, TIMEOUT_ERR;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [BW-1:0] m_bal;
  logic [N-1:0]  m_gnt;
  int            m_g, m_ptr, m_wait;
  bit            m_resp, m_done, m_ok, m_nsf, m_to;

  atm_account_arbiter #(.N_REQ(N), .BAL_W(BW), .MONTO_W(MW), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset), .REQ(REQ), .OP_STB(OP_STB), .OP_TIPO(OP_TIPO),
    .OP_MONTO(OP_MONTO), .LOAD_STB(LOAD_STB), .LOAD_VAL(LOAD_VAL), .GNT(GNT),
    .BALANCE(BALANCE), .DONE(DONE), .OK(OK),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level view: who holds the grant, how long it has been held,
  // and what happens to the balance when the holder's operation arrives.
  task automatic model_step();
    logic [MW-1:0] amt;
    m_done = 0; m_ok = 0; m_nsf = 0; m_to = 0;
    if (reset) begin
      m_bal = '0; m_g = -1; m_resp = 0; m_ptr = N - 1; m_wait = 0;
    end else if (m_resp) begin
      m_resp = 0; m_g = -1;
    end else if (m_g < 0) begin
      if (LOAD_STB) m_bal = LOAD_VAL;
      else
        for (int k = 1; k <= N; k++)
          if (m_g < 0 && REQ[(m_ptr + k) % N]) begin
            m_g = (m_ptr + k) % N; m_ptr = m_g; m_wait = 1;
          end
    end else begin
      amt = OP_MONTO[m_g*MW +: MW];
      if (OP_STB[m_g]) begin
        m_done = 1; m_resp = 1;
        if (!OP_TIPO[m_g]) begin
          m_ok = 1;
          if (BW'(amt) > ~m_bal) m_bal = '1;
          else m_bal = m_bal + BW'(amt);
        end else if (m_bal >= BW'(amt)) begin
          m_bal = m_bal - BW'(amt); m_ok = 1;
        end else m_nsf = 1;
      end else if (!REQ[m_g]) m_g = -1;
      else if (m_wait == TOUT) begin m_to = 1; m_g = -1; end
      else m_wait++;
    end
    m_gnt = (m_g >= 0) ? (N'(1) << m_g) : '0;
  endtask

  // One clock: predict, let the edge happen, compare, drop one-cycle strobes.
  task automatic tick();
    model_step();
    @(posedge clk); #1;
    chk("gnt", BW'(GNT), BW'(m_gnt));
    chk("balance", BALANCE, m_bal);
    chk("done", BW'(DONE), BW'(m_done));
    chk("ok", BW'(OK), BW'(m_ok));
    chk("fondos", BW'(FONDOS_INSUFICIENTES), BW'(m_nsf));
    chk("timeout", BW'(TIMEOUT_ERR), BW'(m_to));
    chk("gnt_onehot", BW'($countones(GNT) <= 1), BW'(1));
    chk("ok_nsf_excl", BW'(OK & FONDOS_INSUFICIENTES), BW'(0));
    OP_STB = '0;
    LOAD_STB = 1'b0;
  endtask

  task automatic wait_gnt(input logic [N-1:0] exp);
    int n = 0;
    while (GNT !== exp && n < 40) begin tick(); n++; end
    chk("wait_gnt", BW'(GNT), BW'(exp));
  endtask

  task automatic op(input int t, input bit tipo, input logic [MW-1:0] amt);
    OP_STB[t] = 1'b1;
    OP_TIPO[t] = tipo;
    OP_MONTO[t*MW +: MW] = amt;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    int cnt;
    reset = 1'b0; REQ = '0; OP_STB = '0; OP_TIPO = '0; OP_MONTO = '0;
    LOAD_STB = 1'b0; LOAD_VAL = '0;
    @(posedge clk); #1;

    // 1: reset, load, deposit 250
    do_reset();
    chk("rst_gnt", BW'(GNT), 0);
    chk("rst_bal", BALANCE, 0);
    chk("rst_done", BW'(DONE), 0);
    LOAD_STB = 1'b1; LOAD_VAL = 1000; tick();
    chk("load_bal", BALANCE, 1000);
    REQ = 4'b0001; tick();
    chk("t1_gnt", BW'(GNT), 4'b0001);
    op(0, 0, 250); tick();
    chk("t1_done", BW'(DONE), 1);
    chk("t1_ok", BW'(OK), 1);
    chk("t1_bal", BALANCE, 1250);
    REQ = '0; tick();
    chk("t1_gnt_off", BW'(GNT), 0);

    // 2: withdrawals with and without sufficient funds
    LOAD_STB = 1'b1; LOAD_VAL = 100; tick();
    REQ = 4'b0100; wait_gnt(4'b0100);
    op(2, 1, 150); tick();
    chk("t2_nsf", BW'(FONDOS_INSUFICIENTES), 1);
    chk("t2_nsf_ok", BW'(OK), 0);
    chk("t2_nsf_bal", BALANCE, 100);
    tick();
    wait_gnt(4'b0100);
    op(2, 1, 100); tick();
    chk("t2_ok", BW'(OK), 1);
    chk("t2_bal", BALANCE, 0);
    REQ = '0; tick();

    // 3: all terminals requesting, round-robin order
    do_reset();
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(N'(1) << order[i]);
      op(order[i], 0, 1); tick();
      chk("t3_bal", BALANCE, BW'(i + 1));
    end
    REQ = '0; tick(); tick();

    // 4: grant timeout, then a strobe on the last allowed cycle
    do_reset();
    REQ = 4'b0110;
    wait_gnt(4'b0010);
    cnt = 1;
    for (int i = 0; i < 40 && TIMEOUT_ERR !== 1'b1; i++) begin
      tick();
      if (GNT === 4'b0010) cnt++;
    end
    chk("t4_to_pulse", BW'(TIMEOUT_ERR), 1);
    chk("t4_to_cycles", BW'(cnt), TOUT);
    chk("t4_to_bal", BALANCE, 0);
    REQ = 4'b0100;
    wait_gnt(4'b0100);
    for (int i = 0; i < TOUT - 1; i++) tick();
    op(2, 0, 5); tick();
    chk("t4_last_done", BW'(DONE), 1);
    chk("t4_last_to", BW'(TIMEOUT_ERR), 0);
    REQ = '0; tick();

    // 5: saturation and a strobe from a non-granted terminal
    LOAD_STB = 1'b1; LOAD_VAL = {BW{1'b1}} - 9; tick();
    REQ = 4'b0001; wait_gnt(4'b0001);
    op(3, 0, 99); tick();
    chk("t5_ignored_done", BW'(DONE), 0);
    chk("t5_ignored_bal", BALANCE, {BW{1'b1}} - 9);
    op(0, 0, 20); tick();
    chk("t5_sat_bal", BALANCE, {BW{1'b1}});
    chk("t5_sat_ok", BW'(OK), 1);
    REQ = '0; tick();

    // 6: load and request together, then reset during a grant
    LOAD_STB = 1'b1; LOAD_VAL = 555; REQ = 4'b0010; tick();
    chk("t6_load_bal", BALANCE, 555);
    chk("t6_load_gnt", BW'(GNT), 0);
    tick();
    chk("t6_gnt", BW'(GNT), 4'b0010);
    reset = 1'b1; op(1, 0, 7); tick(); reset = 1'b0;
    chk("t6_rst_gnt", BW'(GNT), 0);
    chk("t6_rst_bal", BALANCE, 0);
    chk("t6_rst_done", BW'(DONE), 0);
    REQ = '0; tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom % 500 == 0);
      if ($urandom % 40 == 0) begin
        LOAD_STB = 1'b1;
        LOAD_VAL = ($urandom % 4 == 0) ? {$urandom, $urandom} : BW'($urandom_range(0, 1000));
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom % 6 == 0) REQ[i] = ~REQ[i];
        OP_STB[i] = ($urandom % 4 == 0);
        OP_TIPO[i] = $urandom % 2;
        OP_MONTO[i*MW +: MW] = ($urandom % 8 == 0) ? MW'($urandom) : MW'($urandom_range(0, 300));
      end
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
